stream_capture_mc: RTL
======================

// Module: stream_capture_mc
// PURPOSE
//  Multi-channel snoop capture: timestamps every valid word on NUM_CH 36-bit streams and writes it to per-channel memory.
//  Sits between the FC snoop streams and on-chip capture RAMs; CPU controls/inspects it over a 4-bit CSR slave.
//  Adds arm/trigger, one-shot or ring mode, per-channel fill pointers and drop counting.
// PARAMETERS
//  NUM_CH    2   number of stream channels (1..8)
//  DATA_W    36  stream word width ({ctrl[3:0],data[31:0]})
//  ADDR_W    20  memory word-address width per channel
//  DEPTH     1024 words per channel buffer (<= 2**ADDR_W, >= 2)
//  TS_W      28  timestamp width; DATA_W+TS_W = 64 (memory word width)
// PORTS
//  clk            in   1              clock
//  reset          in   1              async, active-high reset
//  csr_address    in   4              CSR word address
//  csr_write      in   1              CSR write strobe
//  csr_read       in   1              CSR read strobe
//  csr_writedata  in   32             CSR write data
//  csr_readdata   out  32             CSR read data, valid 1 cycle after csr_read
//  st_data        in   NUM_CH*DATA_W  stream words, ch n at [n*DATA_W +: DATA_W]
//  st_valid       in   NUM_CH         per-channel word valid (no backpressure)
//  mem_address    out  NUM_CH*ADDR_W  per-channel write word address
//  mem_writedata  out  NUM_CH*64      {timestamp[TS_W-1:0], st_data word}
//  mem_write      out  NUM_CH         per-channel write strobe, 1 cycle per word
//  snoop_reset    out  1              reset to snoop path, = CTRL.snoop_rst
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; CTRL, pointers, counters, timestamp 0.
//  CSR map: 0 CTRL rw {b0 arm(W1 pulse), b1 stop(W1 pulse), b2 ring, b3 trig_en, b4 snoop_rst}; reads b2..b4, b0/b1 read 0.
//   1 STATUS ro {b1:0 state, b8+n full/wrapped[n]}; 2 TRIG rw b3:0 ctrl-nibble mask; 3 DROPS ro sum of words lost while full.
//   8+n PTR[n] ro words written by ch n (ADDR_W+1 bits, zero-extended); unmapped addresses read 0, writes ignored.
//  FSM: IDLE(0) -arm-> ARMED(1); ARMED -trigger-> CAPTURE(2); CAPTURE -all ch full (one-shot) or stop-> DONE(3);
//   DONE -arm-> ARMED; stop in ARMED -> DONE. Arm and stop in same write: stop wins, arm ignored.
//  Arm clears pointers, full flags, DROPS and timestamp in the same cycle state enters ARMED.
//  Trigger: trig_en=0 -> immediate (ARMED lasts exactly 1 cycle); trig_en=1 -> first cycle any ch has
//   st_valid and (ctrl nibble & TRIG) != 0. Trigger word itself is captured.
//  Capture pipeline: 1 cycle; word accepted at cycle t -> mem_write/address/writedata at t+1, address = PTR before increment.
//  Timestamp: free-running TS_W counter from arm, wraps silently; sampled at acceptance cycle.
//  One-shot (ring=0): ch n stops when PTR[n]==DEPTH, full[n]=1; further valid words increment DROPS (saturates at 2**32-1).
//  Ring (ring=1): address = PTR mod DEPTH, PTR wraps 2*DEPTH-1->0; first wrap sets wrapped[n]; never drops, ends only on stop.
//  Simultaneous valid on several channels: all written in the same cycle (independent memories).
//  Stop: words accepted in the stop-write cycle are NOT captured; in-flight pipelined write still issues.
//  Ring bit changes take effect only at next arm (latched on arm).
//  Async reset mid-capture: state IDLE immediately, mem_write deasserts without completing pending write.
// TESTING
//  1 Reset, read all CSRs -> 0; mem_write=0, snoop_reset=0.
//  2 NUM_CH=2, trig_en=0, arm, 5 valid words ch0 -> 5 writes addr 0..4, PTR[0]=5, PTR[1]=0, ts increasing.
//  3 DEPTH=4 one-shot, 6 words ch0 and ch1 each -> 4 writes per ch, STATUS full=2'b11, state DONE, DROPS=4.
//  4 Ring, DEPTH=4, 6 words ch0 -> addrs 0,1,2,3,0,1, wrapped[0]=1, state stays CAPTURE until stop.
//  5 trig_en=1, TRIG=4'h1: ctrl 0,0,1,0 words -> capture starts at 3rd word, PTR=2.
//  6 Write CTRL arm+stop together in IDLE -> state DONE; assert reset during CAPTURE -> state IDLE, no write next cycle.

Source files
------------

// File: rtl/stream_capture_mc.sv
// Multi-channel snoop capture: timestamps valid words on NUM_CH streams and writes them to
// per-channel capture memories, with arm/trigger control and one-shot or ring fill.

module stream_capture_lane #(
    parameter int DATA_W = 36,
    parameter int ADDR_W = 20,
    parameter int DEPTH  = 1024,
    parameter int TS_W   = 28
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clr,
    input  logic                     en,
    input  logic                     ring,
    input  logic                     valid,
    input  logic [DATA_W-1:0]        data,
    input  logic [TS_W-1:0]          ts,
    output logic [ADDR_W:0]          ptr,
    output logic                     flag,
    output logic                     drop,
    output logic [ADDR_W-1:0]        wr_addr,
    output logic [TS_W+DATA_W-1:0]   wr_data,
    output logic                     wr_en
);
    localparam int PW = ADDR_W + 1;
    localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
    localparam logic [PW-1:0] LAST_P  = PW'(2 * DEPTH - 1);

    typedef struct packed {
        logic [ADDR_W-1:0]      addr;
        logic [TS_W+DATA_W-1:0] data;
    } wr_req_t;

    logic [PW-1:0] ptr_q, ptr_inc, ptr_nxt, addr_full;
    logic          flag_q, accept, wr_vld;
    wr_req_t       req_q;

    // A full one-shot lane refuses words; a ring lane always accepts and only flags the wrap.
    assign accept    = en && valid && (ring || !flag_q);
    assign drop      = valid && !ring && flag_q;
    assign ptr_inc   = ptr_q + 1'b1;
    assign ptr_nxt   = (ring && ptr_q == LAST_P) ? '0 : ptr_inc;
    assign addr_full = (ptr_q >= DEPTH_P) ? ptr_q - DEPTH_P : ptr_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q  <= '0;
            flag_q <= 1'b0;
            wr_vld <= 1'b0;
            req_q  <= '0;
        end else begin
            wr_vld <= accept;
            if (accept)
                req_q <= '{addr: addr_full[ADDR_W-1:0], data: {ts, data}};
            if (clr) begin
                ptr_q  <= '0;
                flag_q <= 1'b0;
            end else if (accept) begin
                ptr_q <= ptr_nxt;
                if (ptr_inc == DEPTH_P)
                    flag_q <= 1'b1;
            end
        end
    end

    assign ptr     = ptr_q;
    assign flag    = flag_q;
    assign wr_addr = req_q.addr;
    assign wr_data = req_q.data;
    assign wr_en   = wr_vld;
endmodule

module stream_capture_mc #(
    parameter int NUM_CH = 2,
    parameter int DATA_W = 36,
    parameter int ADDR_W = 20,
    parameter int DEPTH  = 1024,
    parameter int TS_W   = 28
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [3:0]               csr_address,
    input  logic                     csr_write,
    input  logic                     csr_read,
    input  logic [31:0]              csr_writedata,
    output logic [31:0]              csr_readdata,
    input  logic [NUM_CH*DATA_W-1:0] st_data,
    input  logic [NUM_CH-1:0]        st_valid,
    output logic [NUM_CH*ADDR_W-1:0] mem_address,
    output logic [NUM_CH*64-1:0]     mem_writedata,
    output logic [NUM_CH-1:0]        mem_write,
    output logic                     snoop_reset
);
    typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, CAPTURE = 2'd2, DONE = 2'd3} state_t;

    state_t                    state, state_nxt;
    logic                      ctrl_ring, ctrl_trig_en, ctrl_snoop_rst, ring_q;
    logic [3:0]                trig_mask;
    logic [TS_W-1:0]           ts;
    logic [31:0]               drops, rd_nxt;
    logic [3:0]                drop_cnt;
    logic [32:0]               drop_sum;
    logic                      ctrl_wr, arm_wr, stop_wr, trigger, cap_en;
    logic [NUM_CH-1:0]         flag, drop, trig_hit;
    logic [NUM_CH-1:0][ADDR_W:0] ptr;
    logic                      unused_ok;

    assign ctrl_wr = csr_write && csr_address == 4'd0;
    assign stop_wr = ctrl_wr && csr_writedata[1];
    assign arm_wr  = ctrl_wr && csr_writedata[0] && !csr_writedata[1];
    assign trigger = !ctrl_trig_en || (|trig_hit);
    // Words seen during a CTRL arm/stop write are never captured.
    assign cap_en  = !stop_wr && !arm_wr &&
                     (state == CAPTURE || (state == ARMED && trigger));
    assign unused_ok = ^csr_writedata[31:5];

    for (genvar n = 0; n < NUM_CH; n++) begin : g_lane
        assign trig_hit[n] = st_valid[n] &&
                             |(st_data[n*DATA_W + DATA_W-4 +: 4] & trig_mask);
        stream_capture_lane #(
            .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .TS_W(TS_W)
        ) u_lane (
            .clk     (clk),
            .reset   (reset),
            .clr     (arm_wr),
            .en      (cap_en),
            .ring    (ring_q),
            .valid   (st_valid[n]),
            .data    (st_data[n*DATA_W +: DATA_W]),
            .ts      (ts),
            .ptr     (ptr[n]),
            .flag    (flag[n]),
            .drop    (drop[n]),
            .wr_addr (mem_address[n*ADDR_W +: ADDR_W]),
            .wr_data (mem_writedata[n*64 +: 64]),
            .wr_en   (mem_write[n])
        );
    end

    always_comb begin
        state_nxt = state;
        if (stop_wr)
            state_nxt = DONE;
        else if (arm_wr)
            state_nxt = ARMED;
        else begin
            case (state)
                ARMED:   if (trigger) state_nxt = CAPTURE;
                CAPTURE: if (!ring_q && (&flag)) state_nxt = DONE;
                default: state_nxt = state;
            endcase
        end
    end

    always_comb begin
        drop_cnt = '0;
        for (int i = 0; i < NUM_CH; i++)
            drop_cnt = drop_cnt + 4'(drop[i]);
        drop_sum = {1'b0, drops} + 33'(drop_cnt);
    end

    always_comb begin
        rd_nxt = '0;
        case (csr_address)
            4'd0: rd_nxt[4:2] = {ctrl_snoop_rst, ctrl_trig_en, ctrl_ring};
            4'd1: begin
                rd_nxt[1:0]        = state;
                rd_nxt[8 +: NUM_CH] = flag;
            end
            4'd2: rd_nxt[3:0] = trig_mask;
            4'd3: rd_nxt      = drops;
            default: begin
                for (int i = 0; i < NUM_CH; i++)
                    if (csr_address == 4'(8 + i))
                        rd_nxt = 32'(ptr[i]);
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            ctrl_ring      <= 1'b0;
            ctrl_trig_en   <= 1'b0;
            ctrl_snoop_rst <= 1'b0;
            ring_q         <= 1'b0;
            trig_mask      <= '0;
            ts             <= '0;
            drops          <= '0;
            csr_readdata   <= '0;
        end else begin
            state        <= state_nxt;
            csr_readdata <= csr_read ? rd_nxt : '0;
            ts           <= arm_wr ? '0 : ts + 1'b1;
            if (ctrl_wr)
                {ctrl_snoop_rst, ctrl_trig_en, ctrl_ring} <= csr_writedata[4:2];
            if (arm_wr)
                ring_q <= csr_writedata[2];
            if (csr_write && csr_address == 4'd2)
                trig_mask <= csr_writedata[3:0];
            // Lost-word count saturates rather than wrapping.
            if (arm_wr)
                drops <= '0;
            else
                drops <= drop_sum[32] ? '1 : drop_sum[31:0];
        end
    end

    assign snoop_reset = ctrl_snoop_rst;
endmodule
